// File: rtl/heichips25_nibble_mem_responder.sv
// Far-end responder: deserializes nibble requests into 32-bit memory accesses, serializes read data back as 8 nibbles.
// Latency: write issues mem_req the cycle after beat 7; read nibbles start the cycle after mem_rvalid, then one commit beat.
// Backpressure: req_ready_o low while a request is in flight; rsp beats hold while rsp_ready_i is low (commit beat ignores it).
module heichips25_nibble_mem_responder #(
   parameter int unsigned               MemAddrWidth = 8,
   parameter logic [MemAddrWidth-1:0]   MemAddrBase  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              req_data_i,
   input  logic [7:0]              req_addr_i,
   input  logic                    req_write_i,
   input  logic                    req_strb_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   output logic [3:0]              rsp_data_o,
   output logic                    rsp_last_o,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic                    mem_we_o,
   output logic [MemAddrWidth-1:0] mem_addr_o,
   output logic [31:0]             mem_wdata_o,
   output logic [3:0]              mem_be_o,
   input  logic                    mem_rvalid_i,
   input  logic [31:0]             mem_rdata_i,
   output logic                    busy_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_WCOLLECT, S_WREQ, S_RREQ, S_RWAIT, S_RSEND, S_COMMIT
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   // data_q holds collected write data, and is reused as the read-data shift register
   logic [31:0] data_q, data_d;
   logic [7:0]  strb_q, strb_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        beat_acc;

   assign beat_acc = req_valid_i & ready_q;

   // State and datapath registers; ready is registered so there is no valid->ready path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Next-state logic: request collection, memory handshake, response serialization
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      strb_d  = strb_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (beat_acc) begin
               addr_d = req_addr_i;
               if (req_write_i) begin
                  data_d  = {28'd0, req_data_i};
                  strb_d  = {7'd0, req_strb_i};
                  cnt_d   = 3'd1;
                  state_d = S_WCOLLECT;
               end else begin
                  state_d = S_RREQ;
               end
            end
         end
         S_WCOLLECT: begin
            if (beat_acc) begin
               data_d[{cnt_q, 2'b00} +: 4] = req_data_i;
               strb_d[cnt_q]               = req_strb_i;
               cnt_d                       = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_d = S_WREQ;
               end
            end
         end
         S_WREQ: begin
            if (mem_gnt_i) begin
               cnt_d   = 3'd0;
               state_d = S_IDLE;
            end
         end
         S_RREQ: begin
            if (mem_gnt_i) begin
               state_d = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (mem_rvalid_i) begin
               data_d  = mem_rdata_i;
               cnt_d   = 3'd0;
               state_d = S_RSEND;
            end
         end
         S_RSEND: begin
            if (rsp_ready_i) begin
               data_d = data_q >> 4;
               cnt_d  = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_d = S_COMMIT;
               end
            end
         end
         S_COMMIT: begin
            cnt_d   = 3'd0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d == S_IDLE) || (state_d == S_WCOLLECT);
   end

   // Outputs decoded from state; memory fields are zero outside the request states
   always_comb begin
      req_ready_o = ready_q;
      busy_o      = (state_q != S_IDLE);
      mem_req_o   = (state_q == S_WREQ) || (state_q == S_RREQ);
      mem_we_o    = (state_q == S_WREQ);
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      rsp_valid_o = (state_q == S_RSEND) || (state_q == S_COMMIT);
      rsp_data_o  = '0;
      rsp_last_o  = 1'b0;
      if (mem_req_o) begin
         mem_addr_o = MemAddrBase + MemAddrWidth'(addr_q);
      end
      if (state_q == S_WREQ) begin
         mem_wdata_o = data_q;
         mem_be_o    = {strb_q[7] | strb_q[6], strb_q[5] | strb_q[4],
                        strb_q[3] | strb_q[2], strb_q[1] | strb_q[0]};
      end else if (state_q == S_RREQ) begin
         mem_be_o = 4'hF;
      end
      if (state_q == S_RSEND) begin
         rsp_data_o = data_q[3:0];
         rsp_last_o = (cnt_q == 3'd7);
      end
   end

endmodule

// File: tb/tb_heichips25_nibble_mem_responder.sv
// Bench for the nibble memory responder: drives request beats, plays the memory, consumes responses.
// Latency: checks every handshake cycle against a word/nibble-level reference model.
// Backpressure: exercises delayed grants, delayed rvalid and toggling rsp_ready.
module tb_heichips25_nibble_mem_responder;

   localparam logic [7:0] BASE = 8'hF0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_data_i = '0;
   logic [7:0]  req_addr_i = '0;
   logic        req_write_i = 1'b0;
   logic        req_strb_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [3:0]  rsp_data_o;
   logic        rsp_last_o;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_we_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   heichips25_nibble_mem_responder #(.MemAddrWidth(8), .MemAddrBase(BASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_data_i(req_data_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i),
      .req_strb_i(req_strb_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o), .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // memory request and response beat must never be active together
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (mem_req_o && rsp_valid_o) begin
            n_fail++;
            $display("FAIL req_rsp_exclusive: mem_req=%b rsp_valid=%b expected not both 1", mem_req_o, rsp_valid_o);
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] model_addr(input logic [7:0] a);
      int s;
      s = (int'(BASE) + int'(a)) % 256;
      return s[7:0];
   endfunction

   function automatic logic [3:0] model_be(input logic [7:0] s);
      logic [3:0] be;
      for (int i = 0; i < 4; i++) be[i] = s[2*i] | s[2*i+1];
      return be;
   endfunction

   function automatic logic [3:0] model_nibble(input logic [31:0] w, input int k);
      logic [31:0] v;
      v = (w >> (4 * k)) & 32'hF;
      return v[3:0];
   endfunction

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(output bit ok);
      int t;
      t = 0;
      while (!req_ready_o && t < 40) begin
         step();
         t++;
      end
      ok = req_ready_o;
      step();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [56:0] obs;
      rst_n = 1'b0;
      step();
      step();
      obs = {req_ready_o, rsp_data_o, rsp_last_o, rsp_valid_o, mem_req_o, mem_we_o,
             mem_addr_o, mem_wdata_o, mem_be_o, busy_o};
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      rst_n = 1'b1;
      n_checks++;
      if (req_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b expected 0", req_ready_o);
      end
      step();
      n_checks++;
      if (req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_release: got %b expected 1", req_ready_o);
      end
   endtask

   task automatic test_write(input logic [7:0] a, input logic [31:0] w, input logic [7:0] s,
                             input int gap, input int gd, input bit rd_pending, input logic [7:0] rd_a);
      bit ok, ok_all;
      logic [45:0] exp_m, obs_m;
      ok_all = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req_valid_i = 1'b1;
         req_write_i = 1'b1;
         req_addr_i  = a;
         req_data_i  = model_nibble(w, k);
         req_strb_i  = s[k];
         wait_accept(ok);
         ok_all = ok_all & ok;
         req_valid_i = 1'b0;
         if (k < 7) repeat (gap) step();
      end
      n_checks++;
      if (ok_all !== 1'b1) begin
         n_fail++;
         $display("FAIL write_beats_accepted: got %b expected 1", ok_all);
      end
      exp_m = {1'b1, 1'b1, model_addr(a), w, model_be(s)};
      obs_m = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
      n_checks++;
      if (obs_m !== exp_m || rsp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL write_mem_fields: got %h rsp_valid=%b expected %h rsp_valid=0", obs_m, rsp_valid_o, exp_m);
      end
      if (rd_pending) begin
         req_valid_i = 1'b1;
         req_write_i = 1'b0;
         req_addr_i  = rd_a;
      end
      for (int i = 0; i < gd; i++) begin
         step();
         obs_m = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
         n_checks++;
         if (obs_m !== exp_m || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_hold: got %h ready=%b expected %h ready=0", obs_m, req_ready_o, exp_m);
         end
      end
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      n_checks++;
      if ({mem_req_o, busy_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin
         n_fail++;
         $display("FAIL write_done: got req/busy/rsp/ready=%b expected 0001",
                  {mem_req_o, busy_o, rsp_valid_o, req_ready_o});
      end
   endtask

   task automatic test_read(input logic [7:0] a, input logic [31:0] rd, input int gd, input int rvd,
                            input bit bp, input int abort_after);
      bit ok, rr;
      int t;
      logic [13:0] exp_m, obs_m;
      logic [5:0]  exp_r, obs_r;
      logic [56:0] obs_all;
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = a;
      wait_accept(ok);
      req_valid_i = 1'b0;
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL read_beat_accepted: got %b expected 1", ok);
      end
      exp_m = {1'b1, 1'b0, model_addr(a), 4'hF};
      for (int i = 0; i <= gd; i++) begin
         if (i > 0) step();
         obs_m = {mem_req_o, mem_we_o, mem_addr_o, mem_be_o};
         n_checks++;
         if (obs_m !== exp_m) begin
            n_fail++;
            $display("FAIL read_mem_fields: cycle %0d got %h expected %h", i, obs_m, exp_m);
         end
      end
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ~rd;
      step();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rvd > 1) repeat (rvd - 1) step();
      n_checks++;
      if ({mem_req_o, rsp_valid_o, busy_o} !== 3'b001) begin
         n_fail++;
         $display("FAIL read_wait: got req/rsp/busy=%b expected 001", {mem_req_o, rsp_valid_o, busy_o});
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rd;
      step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      for (int k = 0; k < 8; k++) begin
         if (k == abort_after) begin
            rst_n = 1'b0;
            #1;
            obs_all = {req_ready_o, rsp_data_o, rsp_last_o, rsp_valid_o, mem_req_o, mem_we_o,
                       mem_addr_o, mem_wdata_o, mem_be_o, busy_o};
            n_checks++;
            if (obs_all !== '0) begin
               n_fail++;
               $display("FAIL async_reset_outputs: got %h expected 0", obs_all);
            end
            step();
            rst_n        = 1'b1;
            mem_rvalid_i = 1'b1;
            step();
            mem_rvalid_i = 1'b0;
            n_checks++;
            if ({req_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
               n_fail++;
               $display("FAIL reset_recover: got ready/busy/rsp=%b expected 100", {req_ready_o, busy_o, rsp_valid_o});
            end
            return;
         end
         t = 0;
         rr = 1'b0;
         while (!rr && t < 10) begin
            rr = bp ? (t % 2 == 1) : 1'b1;
            rsp_ready_i = rr;
            exp_r = {1'b1, (k == 7), model_nibble(rd, k)};
            obs_r = {rsp_valid_o, rsp_last_o, rsp_data_o};
            n_checks++;
            if (obs_r !== exp_r) begin
               n_fail++;
               $display("FAIL rsp_nibble: idx %0d got %h expected %h", k, obs_r, exp_r);
            end
            step();
            t++;
         end
      end
      rsp_ready_i = 1'b0;
      n_checks++;
      if ({rsp_valid_o, rsp_last_o, rsp_data_o, mem_req_o} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL commit_beat: got %b expected 1000000", {rsp_valid_o, rsp_last_o, rsp_data_o, mem_req_o});
      end
      step();
      n_checks++;
      if ({rsp_valid_o, busy_o, req_ready_o} !== 3'b001) begin
         n_fail++;
         $display("FAIL read_done: got rsp/busy/ready=%b expected 001", {rsp_valid_o, busy_o, req_ready_o});
      end
   endtask

   task automatic test_write_basic();
      test_write(8'h5A, 32'hDEADBEEF, 8'hFF, 0, 0, 1'b0, 8'h00);
   endtask

   task automatic test_write_strobe_wrap();
      test_write(8'h20, $urandom, 8'b0011_0000, 0, 1, 1'b0, 8'h00);
   endtask

   task automatic test_read_basic();
      test_read(8'h12, 32'h12345678, 0, 3, 1'b0, 8);
   endtask

   task automatic test_backpressure();
      test_read(8'h77, 32'hCAFEF00D, 5, 2, 1'b1, 8);
      test_write(8'hE5, 32'h0BADC0DE, 8'b1000_0001, 0, 5, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      test_write(8'h33, 32'hA5A55A5A, 8'hFF, 2, 3, 1'b1, 8'h44);
      test_read(8'h44, 32'h0F1E2D3C, 0, 1, 1'b0, 8);
   endtask

   task automatic test_reset_midread();
      test_read(8'h9C, 32'h87654321, 1, 1, 1'b0, 3);
      test_read(8'h9C, 32'h13579BDF, 0, 1, 1'b0, 8);
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            test_write(8'($urandom), $urandom, 8'($urandom), $urandom_range(0, 2),
                       $urandom_range(0, 3), 1'b0, 8'h00);
         end else begin
            test_read(8'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                      1'($urandom_range(0, 1)), 8);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_write_strobe_wrap();
      test_read_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_midread();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
